// File: rtl/alu_seq_ctrl.sv
// alu_seq_ctrl: sequencer in front of an external combinational 4-bit ALU.
// It accepts a command, either loading the accumulator or executing an ALU op.
// It then spends one EXEC cycle letting the ALU settle and captures the result.
// The result is held in DONE until the consumer takes it.
// Optional feature macro: ALU_SEQ_CNT_EN adds op_count[7:0]. This is a
// saturating count of executed ALU operations.
module alu_seq_ctrl (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic       in_load,
  input  logic [2:0] in_op,
  input  logic [3:0] in_b,
  output logic [3:0] alu_a,
  output logic [3:0] alu_b,
  output logic [2:0] alu_op,
  input  logic [3:0] alu_result,
  input  logic       alu_carry,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [3:0] out_result,
  output logic       out_carry,
`ifdef ALU_SEQ_CNT_EN
  output logic [7:0] op_count,
`endif
  output logic       out_zero
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t     state_reg;
  state_t     state_next;
  logic [3:0] acc_reg;
  logic       accept_load;
  logic       accept_exec;
  logic       capture;

  // ALU operand A is the accumulator itself
  assign alu_a = acc_reg;

  // State register; reset returns to IDLE immediately, aborting any command
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic and handshake / datapath enables
  always_comb begin
    state_next  = state_reg;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    accept_load = 1'b0;
    accept_exec = 1'b0;
    capture     = 1'b0;
    case (state_reg)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          if (in_load) begin
            accept_load = 1'b1;
          end else begin
            accept_exec = 1'b1;
            state_next  = EXEC;
          end
        end
      end
      EXEC: begin
        capture    = 1'b1;
        state_next = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Accumulator: written by a load, or by the ALU result at the end of EXEC
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_reg <= 4'd0;
    end else if (accept_load) begin
      acc_reg <= in_b;
    end else if (capture) begin
      acc_reg <= alu_result;
    end
  end

  // ALU operand B and opcode change only when an execute command is accepted
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_b  <= 4'd0;
      alu_op <= 3'd0;
    end else if (accept_exec) begin
      alu_b  <= in_b;
      alu_op <= in_op;
    end
  end

  // Result capture at the closing edge of EXEC; held through DONE and IDLE
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_result <= 4'd0;
      out_carry  <= 1'b0;
      out_zero   <= 1'b0;
    end else if (capture) begin
      out_result <= alu_result;
      out_carry  <= alu_carry;
      out_zero   <= (alu_result == 4'd0);
    end
  end

`ifdef ALU_SEQ_CNT_EN
  logic [7:0] op_count_reg;

  assign op_count = op_count_reg;

  // Saturating count of EXEC-to-DONE transitions; loads never count
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_count_reg <= 8'd0;
    end else if (capture && (op_count_reg != 8'hFF)) begin
      op_count_reg <= op_count_reg + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Testbench for alu_seq_ctrl with a reference ALU and a result scoreboard.
// Define ALU_SEQ_CNT_EN to also exercise op_count.
module tb_alu_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic       in_load;
  logic [2:0] in_op;
  logic [3:0] in_b;
  logic [3:0] alu_a;
  logic [3:0] alu_b;
  logic [2:0] alu_op;
  logic [3:0] alu_result;
  logic       alu_carry;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_result;
  logic       out_carry;
  logic       out_zero;
`ifdef ALU_SEQ_CNT_EN
  logic [7:0] op_count;
`endif

  typedef struct {
    logic [3:0] res;
    logic       carry;
    logic       zero;
  } exp_t;

  exp_t       sb[$];
  int         n_pass = 0;
  int         n_total = 0;
  logic [3:0] m_acc = 4'd0;
  int         m_cnt = 0;

  always #5 clk = ~clk;

  // Reference ALU: returns {carry, result}; sub carry is the inverted borrow
  function automatic logic [4:0] alu_fn(input logic [2:0] op, input logic [3:0] a,
                                        input logic [3:0] b);
    logic [4:0] r;
    case (op)
      3'd0:    r = {1'b0, a} + {1'b0, b};
      3'd1:    r = {1'b0, a} + {1'b0, ~b} + 5'd1;
      3'd2:    r = {1'b0, a & b};
      3'd3:    r = {1'b0, a | b};
      3'd4:    r = {1'b0, a ^ b};
      3'd5:    r = {1'b0, ~a};
      3'd6:    r = {1'b0, a << b};
      default: r = {1'b0, a >> b};
    endcase
    return r;
  endfunction

  assign {alu_carry, alu_result} = alu_fn(alu_op, alu_a, alu_b);

  alu_seq_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_load    (in_load),
    .in_op      (in_op),
    .in_b       (in_b),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_op     (alu_op),
    .alu_result (alu_result),
    .alu_carry  (alu_carry),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_carry  (out_carry),
`ifdef ALU_SEQ_CNT_EN
    .op_count   (op_count),
`endif
    .out_zero   (out_zero)
  );

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One command from IDLE; for execute, follow it through EXEC and DONE with
  // 'stall' cycles of backpressure during which a stray load is offered
  task automatic do_cmd(input logic ld, input logic [2:0] op, input logic [3:0] b,
                        input int stall);
    logic [4:0] e;
    exp_t       x;
    in_valid = 1'b1;
    in_load  = ld;
    in_op    = op;
    in_b     = b;
    check("ready_idle", {7'd0, in_ready}, 8'd1);
    step();
    in_valid = 1'b0;
    in_load  = 1'b0;
    in_op    = 3'($urandom);
    in_b     = 4'($urandom);
    if (ld) begin
      m_acc = b;
      check("load_acc", {4'd0, alu_a}, {4'd0, b});
      check("load_no_out", {7'd0, out_valid}, 8'd0);
      check("load_ready", {7'd0, in_ready}, 8'd1);
    end else begin
      e = alu_fn(op, m_acc, b);
      sb.push_back('{e[3:0], e[4], (e[3:0] == 4'd0)});
      check("exec_no_valid", {7'd0, out_valid}, 8'd0);
      check("exec_not_ready", {7'd0, in_ready}, 8'd0);
      check("alu_op_reg", {5'd0, alu_op}, {5'd0, op});
      check("alu_b_reg", {4'd0, alu_b}, {4'd0, b});
      step();
      m_acc = e[3:0];
      if (m_cnt < 255) m_cnt++;
      check("latency_valid", {7'd0, out_valid}, 8'd1);
      x = sb.pop_front();
      check("out_result", {4'd0, out_result}, {4'd0, x.res});
      check("out_carry", {7'd0, out_carry}, {7'd0, x.carry});
      check("out_zero", {7'd0, out_zero}, {7'd0, x.zero});
      check("acc_update", {4'd0, alu_a}, {4'd0, m_acc});
`ifdef ALU_SEQ_CNT_EN
      check("op_count", op_count, 8'(m_cnt));
`endif
      if (stall > 0) begin
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_load   = 1'b1;
        in_b      = ~m_acc;
        for (int i = 0; i < stall; i++) begin
          step();
          check("hold_valid", {7'd0, out_valid}, 8'd1);
          check("hold_ready", {7'd0, in_ready}, 8'd0);
          check("hold_result", {4'd0, out_result}, {4'd0, x.res});
          check("hold_acc", {4'd0, alu_a}, {4'd0, m_acc});
          check("hold_alu_b", {4'd0, alu_b}, {4'd0, b});
          check("hold_alu_op", {5'd0, alu_op}, {5'd0, op});
        end
        in_valid  = 1'b0;
        in_load   = 1'b0;
        out_ready = 1'b1;
      end
      step();
      check("done_released", {7'd0, out_valid}, 8'd0);
      check("back_to_idle", {7'd0, in_ready}, 8'd1);
      check("acc_after", {4'd0, alu_a}, {4'd0, m_acc});
    end
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_load   = 1'b0;
    in_op     = 3'd0;
    in_b      = 4'd0;
    out_ready = 1'b1;
    #1;
    check("rst_out_valid", {7'd0, out_valid}, 8'd0);
    check("rst_out_result", {4'd0, out_result}, 8'd0);
    check("rst_alu_a", {4'd0, alu_a}, 8'd0);
    check("rst_alu_b", {4'd0, alu_b}, 8'd0);
    check("rst_alu_op", {5'd0, alu_op}, 8'd0);
    @(negedge clk);
    rst = 1'b0;
    step();
    check("ready_after_rst", {7'd0, in_ready}, 8'd1);

    // Load 5, add 3 -> 8
    do_cmd(1'b1, 3'd0, 4'd5, 0);
    do_cmd(1'b0, 3'd0, 4'd3, 0);
    // Carry: 8 + 9 -> 1, carry 1
    do_cmd(1'b0, 3'd0, 4'd9, 0);
    // Zero: 1 - 1 -> 0, carry 1 (no borrow)
    do_cmd(1'b0, 3'd1, 4'd1, 0);
    // Backpressure: load 3, shl 1 -> 6 held for 3 cycles
    do_cmd(1'b1, 3'd0, 4'd3, 0);
    do_cmd(1'b0, 3'd6, 4'd1, 3);
    // Remaining opcodes, including a borrowing subtract and a wrapping add
    do_cmd(1'b0, 3'd2, 4'hC, 0);
    do_cmd(1'b0, 3'd3, 4'h3, 0);
    do_cmd(1'b0, 3'd4, 4'h5, 0);
    do_cmd(1'b0, 3'd5, 4'h0, 0);
    do_cmd(1'b0, 3'd7, 4'h2, 1);
    do_cmd(1'b0, 3'd1, 4'h5, 0);
    do_cmd(1'b0, 3'd0, 4'h2, 0);

    // Reset in the middle of EXEC aborts the command
    do_cmd(1'b1, 3'd0, 4'd7, 0);
    in_valid = 1'b1;
    in_load  = 1'b0;
    in_op    = 3'd0;
    in_b     = 4'd2;
    step();
    in_valid = 1'b0;
    check("pre_rst_exec", {7'd0, in_ready}, 8'd0);
    #2 rst = 1'b1;
    #1;
    check("arst_out_valid", {7'd0, out_valid}, 8'd0);
    check("arst_out_result", {4'd0, out_result}, 8'd0);
    check("arst_out_carry", {7'd0, out_carry}, 8'd0);
    check("arst_out_zero", {7'd0, out_zero}, 8'd0);
    check("arst_acc", {4'd0, alu_a}, 8'd0);
    check("arst_alu_b", {4'd0, alu_b}, 8'd0);
    check("arst_alu_op", {5'd0, alu_op}, 8'd0);
    check("arst_in_ready", {7'd0, in_ready}, 8'd1);
    m_acc = 4'd0;
    m_cnt = 0;
`ifdef ALU_SEQ_CNT_EN
    check("arst_op_count", op_count, 8'd0);
`endif
    @(negedge clk);
    rst = 1'b0;
    step();
    check("abort_no_valid", {7'd0, out_valid}, 8'd0);
    check("abort_ready", {7'd0, in_ready}, 8'd1);
    do_cmd(1'b0, 3'd0, 4'd4, 0);

`ifdef ALU_SEQ_CNT_EN
    // 300 operations and 10 loads: the counter must saturate
    for (int i = 0; i < 310; i++) begin
      if (i % 31 == 0) do_cmd(1'b1, 3'd0, 4'($urandom), 0);
      else             do_cmd(1'b0, 3'(i % 8), 4'($urandom), 0);
    end
    check("op_count_sat", op_count, 8'd255);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
